// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-through, no-write-allocate data cache: one 32-bit word per line,
// load hits answer combinationally, misses and stores go to backing memory over req/ack.
module dcache_direct_mapped #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [2:0]            size_ctr,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES];
    logic [31:0]           hit_cnt_q;
    logic [31:0]           miss_cnt_q;

    logic [1:0]            off;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic                  line_hit;
    logic                  ld_size_ok;
    logic                  st_size_ok;
    logic                  is_load;
    logic                  is_store;
    logic                  fill_en;
    logic                  merge_en;
    logic [DATA_WIDTH-1:0] line_word;
    logic [DATA_WIDTH-1:0] line_wdata_d;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [DATA_WIDTH-1:0] ext_data;

    assign off = addr[1:0];
    assign idx = addr[INDEX_BITS+1:2];
    assign tag = addr[ADDR_WIDTH-1:INDEX_BITS+2];

    assign line_word = data_q[idx];
    assign line_hit  = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        ld_size_ok = 1'b0;
        st_size_ok = 1'b0;
        case (size_ctr)
            3'b000, 3'b001, 3'b010: begin
                ld_size_ok = 1'b1;
                st_size_ok = 1'b1;
            end
            3'b100, 3'b101: ld_size_ok = 1'b1;
            default: ;
        endcase
    end

    // A store request shadows a simultaneous load, even when the store size is invalid.
    assign is_store = mem_write && st_size_ok;
    assign is_load  = !mem_write && mem_read && ld_size_ok;

    assign mem_req   = (state_q == S_FETCH) || (state_q == S_WRITE);
    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = {addr[ADDR_WIDTH-1:2], 2'b00};
    assign mem_wdata = wdata << {off, 3'b000};

    always_comb begin
        case (size_ctr[1:0])
            2'b00:   mem_wstrb = 4'b0001 << off;
            2'b01:   mem_wstrb = 4'b0011 << {off[1], 1'b0};
            default: mem_wstrb = 4'b1111;
        endcase
    end

    assign lane_b = line_word[{off, 3'b000} +: 8];
    assign lane_h = off[1] ? line_word[31:16] : line_word[15:0];

    always_comb begin
        case (size_ctr)
            3'b000:  ext_data = {{24{lane_b[7]}}, lane_b};
            3'b100:  ext_data = {24'd0, lane_b};
            3'b001:  ext_data = {{16{lane_h[15]}}, lane_h};
            3'b101:  ext_data = {16'd0, lane_h};
            3'b010:  ext_data = line_word;
            default: ext_data = '0;
        endcase
    end

    always_comb begin
        rdata = '0;
        stall = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = is_store || (is_load && !line_hit);
                if (is_load && line_hit) begin
                    rdata = ext_data;
                end
            end
            S_FETCH, S_WRITE: stall = 1'b1;
            S_DONE: begin
                if (is_load) begin
                    rdata = ext_data;
                end
            end
            default: ;
        endcase
    end

    // Merge only the strobed lanes of a write-through into a resident line.
    always_comb begin
        line_wdata_d = line_word;
        for (int l = 0; l < 4; l++) begin
            if (mem_wstrb[l]) begin
                line_wdata_d[8*l +: 8] = mem_wdata[8*l +: 8];
            end
        end
    end

    assign fill_en  = (state_q == S_FETCH) && mem_ack;
    assign merge_en = (state_q == S_WRITE) && mem_ack && line_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_store) begin
                        state_q <= S_WRITE;
                    end else if (is_load) begin
                        if (line_hit) begin
                            hit_cnt_q <= hit_cnt_q + 32'd1;
                        end else begin
                            miss_cnt_q <= miss_cnt_q + 32'd1;
                            state_q    <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        valid_q[idx] <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_q[idx] <= mem_rdata;
            tag_q[idx]  <= tag;
        end else if (merge_en) begin
            data_q[idx] <= line_wdata_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed plan scenarios plus random traffic against a byte-level memory and tag model.
module tb_dcache_direct_mapped;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size_ctr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_assert = 0;
    int n_fail   = 0;

    byte unsigned ref_mem[int];
    byte unsigned bk_mem[int];
    bit           m_valid[64];
    int           m_tag[64];
    int           m_hits;
    int           m_misses;
    logic [31:0]  last_rd;

    dcache_direct_mapped dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wdata      (wdata),
        .size_ctr   (size_ctr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .rdata      (rdata),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic byte unsigned init_byte(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    function automatic byte unsigned ref_b(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic byte unsigned bk_b(input int a);
        return bk_mem.exists(a) ? bk_mem[a] : init_byte(a);
    endfunction

    function automatic logic [31:0] ref_word(input int wa);
        return {ref_b(wa + 3), ref_b(wa + 2), ref_b(wa + 1), ref_b(wa)};
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] sz, input int off);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (sz)
            3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd5:    return h;
            3'd2:    return w;
            default: return 32'd0;
        endcase
    endfunction

    // Drives one request and plays the backing memory until the core may retire it.
    task automatic access(input bit rd, input bit wr, input logic [16:0] a, input logic [31:0] wd,
                          input logic [2:0] sz, input int lat, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdat, output logic [31:0] rd_o, output int stalls);
        int  reqs;
        bit  done;
        int  ma;
        addr      = a;
        wdata     = wd;
        size_ctr  = sz;
        mem_read  = rd;
        mem_write = wr;
        mem_ack   = 1'b0;
        stalls    = 0;
        reqs      = 0;
        done      = 0;
        rd_o      = '0;
        for (int c = 0; c < 300 && !done; c++) begin
            #1;
            if (!stall) begin
                rd_o = rdata;
                done = 1;
                check("retire_req", {31'd0, mem_req}, 32'd0);
            end else begin
                stalls++;
                mem_rdata = $urandom;
                if (mem_req) begin
                    reqs++;
                    check("bus_addr", {15'd0, mem_addr}, {15'd0, a[16:2], 2'b00});
                    check("bus_we", {31'd0, mem_we}, {31'd0, wr});
                    if (wr) begin
                        check("bus_strb", {28'd0, mem_wstrb}, {28'd0, exp_strb});
                        check("bus_wdata", mem_wdata, exp_wdat);
                    end
                    if (reqs == lat) begin
                        mem_ack = 1'b1;
                        ma = int'(mem_addr);
                        if (mem_we) begin
                            for (int l = 0; l < 4; l++)
                                if (mem_wstrb[l]) bk_mem[ma + l] = mem_wdata[8*l +: 8];
                        end else begin
                            mem_rdata = {bk_b(ma + 3), bk_b(ma + 2), bk_b(ma + 1), bk_b(ma)};
                        end
                    end
                end
                @(negedge clk);
                mem_ack = 1'b0;
            end
        end
        if (!done) check("timeout", 32'd0, 32'd1);
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic run(input string nm, input bit rd, input bit wr, input logic [16:0] a,
                       input logic [31:0] wd, input logic [2:0] sz, input int lat);
        int          ix, tg, off, wa, nb, stalls, exp_stall;
        bit          st_ok, ld_ok, hit;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdat, exp_rd, obs_rd;
        ix    = int'(a[7:2]);
        tg    = int'(a[16:8]);
        off   = int'(a[1:0]);
        wa    = int'(a) & ~3;
        st_ok = wr && (sz == 3'd0 || sz == 3'd1 || sz == 3'd2);
        ld_ok = !wr && rd && (sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        hit   = ld_ok && m_valid[ix] && (m_tag[ix] == tg);
        nb    = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
        if (sz == 3'd0)      exp_strb = 4'b0001 << off;
        else if (sz == 3'd1) exp_strb = 4'b0011 << (off & 2);
        else                 exp_strb = 4'b1111;
        exp_wdat  = wd << (8 * off);
        exp_rd    = ld_ok ? extend(ref_word(wa), sz, off) : 32'd0;
        exp_stall = (st_ok || (ld_ok && !hit)) ? 1 + lat : 0;
        access(rd, wr, a, wd, sz, lat, exp_strb, exp_wdat, obs_rd, stalls);
        if (ld_ok && hit) m_hits++;
        if (ld_ok && !hit) begin
            m_misses++;
            m_valid[ix] = 1;
            m_tag[ix]   = tg;
        end
        if (st_ok)
            for (int k = 0; k < nb; k++) ref_mem[int'(a) + k] = 8'(wd >> (8 * k));
        check({nm, "_rdata"}, obs_rd, exp_rd);
        check({nm, "_stalls"}, 32'(stalls), 32'(exp_stall));
        check({nm, "_hits"}, hit_count, 32'(m_hits));
        check({nm, "_misses"}, miss_count, 32'(m_misses));
        last_rd = obs_rd;
    endtask

    initial begin
        logic [16:0] ra;
        logic [2:0]  rsz;
        int          op, roff;
        rst       = 1'b1;
        addr      = '0;
        wdata     = '0;
        size_ctr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        m_hits    = 0;
        m_misses  = 0;
        foreach (m_valid[i]) m_valid[i] = 0;
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_hits", hit_count, 32'd0);
        check("rst_misses", miss_count, 32'd0);

        ref_mem[32'h100] = 8'hEF; ref_mem[32'h101] = 8'hBE;
        ref_mem[32'h102] = 8'hAD; ref_mem[32'h103] = 8'hDE;
        bk_mem[32'h100]  = 8'hEF; bk_mem[32'h101]  = 8'hBE;
        bk_mem[32'h102]  = 8'hAD; bk_mem[32'h103]  = 8'hDE;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run("t1_miss", 1, 0, 17'h00100, 32'd0, 3'd2, 3);
        check("t1_miss_data", last_rd, 32'hDEADBEEF);
        run("t1_hit", 1, 0, 17'h00100, 32'd0, 3'd2, 3);
        check("t1_hit_data", last_rd, 32'hDEADBEEF);
        check("t1_hit_cnt", hit_count, 32'd1);
        check("t1_miss_cnt", miss_count, 32'd1);

        run("t2_lb", 1, 0, 17'h00103, 32'd0, 3'd0, 1);
        check("t2_lb_val", last_rd, 32'hFFFFFFDE);
        run("t2_lbu", 1, 0, 17'h00103, 32'd0, 3'd4, 1);
        check("t2_lbu_val", last_rd, 32'h000000DE);
        run("t2_lh", 1, 0, 17'h00102, 32'd0, 3'd1, 1);
        check("t2_lh_val", last_rd, 32'hFFFFDEAD);
        run("t2_lhu", 1, 0, 17'h00100, 32'd0, 3'd5, 1);
        check("t2_lhu_val", last_rd, 32'h0000BEEF);

        run("t3_sb", 0, 1, 17'h00101, 32'h000000AB, 3'd0, 2);
        run("t3_lw", 1, 0, 17'h00100, 32'd0, 3'd2, 1);
        check("t3_merged", last_rd, 32'hDEADABEF);

        run("t4_sh", 0, 1, 17'h02002, 32'h00001234, 3'd1, 2);
        run("t4_lw", 1, 0, 17'h02000, 32'd0, 3'd2, 2);
        check("t4_miss_cnt", miss_count, 32'd2);

        run("t5_a", 1, 0, 17'h00100, 32'd0, 3'd2, 1);
        run("t5_b", 1, 0, 17'h01100, 32'd0, 3'd2, 1);
        run("t5_c", 1, 0, 17'h00100, 32'd0, 3'd2, 1);
        check("t5_miss_cnt", miss_count, 32'd5);

        run("inv_st", 0, 1, 17'h00100, 32'hFFFFFFFF, 3'd3, 1);
        run("inv_ld", 1, 0, 17'h00100, 32'd0, 3'd6, 1);

        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0:       ra = 17'h00100;
                1:       ra = 17'h01100;
                default: ra = 17'h02000;
            endcase
            ra[3:2] = 2'($urandom_range(0, 3));
            if (op >= 2) rsz = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: rsz = 3'd0; 1: rsz = 3'd1; 2: rsz = 3'd2; 3: rsz = 3'd4;
                    default: rsz = 3'd5;
                endcase
            end
            if (rsz == 3'd0 || rsz == 3'd4)      roff = $urandom_range(0, 3);
            else if (rsz == 3'd1 || rsz == 3'd5) roff = 2 * $urandom_range(0, 1);
            else                                 roff = 0;
            ra[1:0] = 2'(roff);
            run("rnd", op != 2, op >= 2, ra, $urandom, rsz, $urandom_range(1, 4));
        end

        addr      = 17'h00300;
        size_ctr  = 3'd2;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        #1;
        check("t6_idle_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        #1;
        check("t6_fetch_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_req_async", {31'd0, mem_req}, 32'd0);
        check("t6_hits_rst", hit_count, 32'd0);
        check("t6_misses_rst", miss_count, 32'd0);
        mem_read = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("t6_late_ack_req", {31'd0, mem_req}, 32'd0);
        check("t6_hits_after", hit_count, 32'd0);
        check("t6_misses_after", miss_count, 32'd0);
        foreach (m_valid[i]) m_valid[i] = 0;
        m_hits   = 0;
        m_misses = 0;
        run("t6_refetch", 1, 0, 17'h00300, 32'd0, 3'd2, 1);
        run("t6_line0", 1, 0, 17'h00100, 32'd0, 3'd2, 1);
        check("t6_miss_cnt", miss_count, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_direct_mapped.md
Name: dcache_direct_mapped

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the core's memory stage and the byte-addressable data memory.
- Takes the same size-coded load/store requests the data memory takes.
- Returns sign- or zero-extended load data and raises a stall while a miss or write-through is outstanding.
- The backing memory is reached over a word-wide req/ack handshake with byte strobes and variable latency.

Parameters:
- ADDR_WIDTH, 17, byte address width.
- DATA_WIDTH, 32, data width (fixed at 32; the byte-lane logic assumes 4 lanes).
- INDEX_BITS, 6, log2 of the number of lines (64 lines of one 32-bit word each).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- addr  in  ADDR_WIDTH  byte address (ALU result).
- wdata  in  32  store data, right-aligned.
- size_ctr  in  3  access size: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- rdata  out  32  extended load data.
- stall  out  1  core must hold its request while this is high.
- mem_req  out  1  backing request valid.
- mem_we  out  1  backing write (1) or read (0).
- mem_addr  out  ADDR_WIDTH  word-aligned backing address (low 2 bits 0).
- mem_wdata  out  32  lane-aligned store data.
- mem_wstrb  out  4  byte strobes.
- mem_rdata  in  32  backing read word.
- mem_ack  in  1  one-cycle completion pulse from the backing memory.
- hit_count  out  32  load-hit counter.
- miss_count  out  32  load-miss counter.

Behaviour:
- Address fields:
  - off = addr[1:0].
  - idx = addr[INDEX_BITS+1:2].
  - tag = addr[ADDR_WIDTH-1:INDEX_BITS+2].
- Each line holds a valid bit, a tag and a 32-bit word. Only valid bits are reset; data and tag arrays need no reset.
- Alignment: accesses must be naturally aligned. Hardware ignores off[0] for halfwords and off[1:0] for words; no fault is raised.
- FSM states: IDLE, FETCH, WRITE, DONE. Reset puts the FSM in IDLE.
- IDLE:
  - Load hit (valid and tag match): rdata is combinational in the same cycle, stall=0, hit_count+1.
  - Load miss: stall=1 in that cycle, miss_count+1, next state FETCH.
  - Store (mem_write=1, size 000/001/010): stall=1, next state WRITE.
  - mem_write has priority when mem_read and mem_write are both high.
  - Store with an invalid size: no backing request, stall=0, no state change.
  - Load with an invalid size: rdata=0, stall=0, no lookup effect, no counting.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr={addr[ADDR_WIDTH-1:2],2'b00}, stall=1.
  - On mem_ack: write mem_rdata into the line, set valid, set tag, next state DONE.
- WRITE:
  - mem_req=1, mem_we=1, stall=1.
  - mem_wdata = wdata << (8*off).
  - mem_wstrb: b = 0001<<off; h = 0011<<{off[1],0}; w = 1111.
  - On mem_ack: if the line hits, merge the strobed bytes into the line (no allocate on a miss), next state DONE.
- DONE:
  - stall=0 for exactly one cycle so the core retires the access; mem_req=0; next state IDLE.
  - For loads, rdata comes from the freshly filled line.
  - DONE does not count as a hit.
- Load extension on the selected byte or half lane:
  - lb/lh sign-extend from bit 7/15.
  - lbu/lhu zero-extend.
  - lw passes through.
- Handshake:
  - mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb stay stable from request until the ack cycle inclusive.
  - mem_ack is ignored when mem_req=0.
  - Backing latency is unbounded: the FSM waits indefinitely.
- Request stability: while stall=1 the core holds addr, wdata, size_ctr, mem_read and mem_write constant. Behaviour is undefined otherwise.
- Output timing: mem_req is decoded from registered state only (no combinational path from the core inputs). stall is combinational.
- Counters: 32-bit, wrap at 2^32-1 to 0.
- Reset (asynchronous, any state, including mid-FETCH or mid-WRITE):
  - All valid bits cleared, FSM to IDLE, counters 0, mem_req=0 immediately.
  - An abandoned fetch does not fill; an abandoned write may or may not have reached memory.
- Reset values of outputs: stall=0 unless a request is present in IDLE; rdata=0 unless a hitting load is presented.

Test Plan:
1. Cold lw at addr 0x00100, backing returns 0xDEADBEEF with ack after 3 cycles -> stall high for 4 cycles (IDLE + 3 FETCH), DONE gives rdata=0xDEADBEEF with stall=0; a repeat lw hits with zero stall; hit=1, miss=1.
2. After scenario 1, lb at 0x00103 -> rdata=0xFFFFFFDE; lbu at 0x00103 -> 0x000000DE; lh at 0x00102 -> 0xFFFFDEAD; lhu at 0x00100 -> 0x0000BEEF; all hits.
3. sb 0xAB at 0x00101 on a hit line -> mem_wstrb=0010, mem_wdata=0x0000AB00, mem_we=1; after ack, lw 0x00100 hits and returns 0xDEADABEF.
4. sh 0x1234 at 0x02002 on a miss -> mem_wstrb=1100, mem_wdata=0x12340000; the following lw at 0x02000 misses (no allocate); miss_count increments.
5. Conflict: lw 0x00100 then lw 0x01100 (same idx, different tag) -> both miss; a third lw 0x00100 misses again.
6. Assert rst during FETCH, before ack -> mem_req drops without waiting for a clock edge; a later ack is ignored; the line stays invalid; counters read 0.
